button_event_arbiter: RTL and testbench
=======================================

// Module: button_event_arbiter
// PURPOSE
//  Collects single-cycle press pulses from N_BTN push-button detector chains, holds each
//  as a pending request, and serialises them round-robin onto one valid/ready event port
//  feeding a shared consumer (mode FSM, display updater). Enforces a hold-off gap after
//  each issued event and counts presses lost because that button's request was still pending.
// PARAMETERS
//  N_BTN    4  number of button requesters (>=2)
//  HOLDOFF  3  idle cycles forced after each accepted event (0 = none)
//  CNT_W    8  width of the saturating drop counter
//  (localparam ID_W = $clog2(N_BTN))
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       asynchronous, active-low reset
//  btn_pulse  in   N_BTN   one-cycle press pulses, already debounced/synchronised
//  evt_valid  out  1       event offered to consumer
//  evt_ready  in   1       consumer accepts event when evt_valid && evt_ready
//  evt_id     out  ID_W    index of button whose event is offered
//  pending    out  N_BTN   registered pending-request flags
//  drop_cnt   out  CNT_W   presses lost (pulse while own pending set), saturating
//  busy       out  1       1 when FSM not in IDLE
// BEHAVIOUR
//  Reset (rst=0, async): evt_valid=0, evt_id=0, pending=0, drop_cnt=0, busy=0,
//   rr pointer=0, hold-off counter=0, state=IDLE. Reset mid-offer drops the event silently.
//  Pending: pulse i sampled at edge k -> pending[i]=1 after k.
//   Cleared at accept edge of event i. Pulse i on its own accept edge -> pending[i] stays 1.
//   Pulse i while pending[i]=1 and not being accepted -> drop; drop_cnt += number of
//   dropped bits that cycle, clamped at all-ones (never wraps).
//  FSM states: IDLE, OFFER, HOLD.
//   IDLE: if |pending -> winner = first set bit scanning ptr, ptr+1, ... wrapping N_BTN-1->0;
//     register evt_id=winner, evt_valid=1, go OFFER. Pulse at edge k, empty FSM ->
//     evt_valid=1 after edge k+1 (2-cycle latency). Only pending flags as of IDLE cycle count.
//   OFFER: evt_valid=1; evt_id stable until accepted (AXI-style, no retraction).
//     On evt_valid&&evt_ready: pending[evt_id] cleared, ptr=(evt_id+1) mod N_BTN,
//     evt_valid=0; HOLDOFF>0 -> HOLD with counter=HOLDOFF, else -> IDLE.
//   HOLD: counter decrements each cycle; at counter==1 -> IDLE. Exactly HOLDOFF cycles
//     with evt_valid=0 between accept and next arbitration cycle. New pulses still latch.
//  Back-to-back (HOLDOFF=0, ready tied 1): one event per 2 cycles (OFFER, IDLE alternate).
//  evt_ready ignored when evt_valid=0. busy = (state!=IDLE), registered-state decode.
// TESTING
//  1 Reset: rst=0 with btn_pulse=4'hF -> all outputs 0; release, no pulses -> evt_valid stays 0.
//  2 Single press: pulse btn2 at edge k, ready=1 -> evt_valid=1,evt_id=2 after k+1;
//    accepted; pending=0; evt_valid=0 for exactly 3 cycles (HOLD) then idle.
//  3 Round-robin: pulse 4'hF in one cycle, ready=1 -> evt_id order 0,1,2,3; then pulse
//    btn0 and btn3 together -> order 0,3 (ptr was 0), drop_cnt=0.
//  4 Backpressure: press btn1, hold ready=0 20 cycles -> evt_valid=1, evt_id=1 stable;
//    pulse btn1 3 times meanwhile -> drop_cnt=3; ready=1 -> single accept, pending[1]=0.
//  5 Same-edge re-press: pulse btn1 on its accept edge -> pending[1]=1, second id=1 event follows.
//  6 Saturation/reset: CNT_W=2, cause 5 drops -> drop_cnt=3; assert rst mid-OFFER ->
//    evt_valid=0 immediately (async), drop_cnt=0, ptr=0.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that turns single-cycle button press pulses into a serial
// valid/ready event stream, with a post-accept hold-off gap and a saturating drop counter.
module button_event_arbiter #(
    parameter  int N_BTN   = 4,
    parameter  int HOLDOFF = 3,
    parameter  int CNT_W   = 8,
    localparam int ID_W    = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic [N_BTN-1:0] pending,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    localparam int HC_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int PC_W  = $clog2(N_BTN + 1);
    localparam int SUM_W = CNT_W + PC_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state_q;
    logic               valid_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    ptr_q;
    logic [HC_W-1:0]    hcnt_q;
    logic [N_BTN-1:0]   pend_q;
    logic [CNT_W-1:0]   drop_q;
    logic               busy_q;

    logic               accept_s;
    logic [N_BTN-1:0]   clr_s;
    logic [N_BTN-1:0]   drop_bits_s;
    logic [N_BTN-1:0]   pend_d;
    logic [CNT_W-1:0]   drop_d;
    logic [ID_W-1:0]    winner_s;
    logic [ID_W-1:0]    ptr_next_s;

    // First set request at or above ptr wins; otherwise the lowest set request below ptr.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [N_BTN-1:0] req,
        input logic [ID_W-1:0]  ptr
    );
        logic [ID_W-1:0] hi_pick;
        logic [ID_W-1:0] lo_pick;
        logic            hi_found;
        hi_pick  = '0;
        lo_pick  = '0;
        hi_found = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            hi_pick  = (req[i] && (ID_W'(i) >= ptr)) ? ID_W'(i) : hi_pick;
            hi_found = hi_found | (req[i] && (ID_W'(i) >= ptr));
            lo_pick  = (req[i] && (ID_W'(i) < ptr)) ? ID_W'(i) : lo_pick;
        end
        return hi_found ? hi_pick : lo_pick;
    endfunction

    function automatic logic [PC_W-1:0] popcnt(input logic [N_BTN-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_BTN; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [PC_W-1:0]  b
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // A press landing on its own accept edge survives because the set wins over the clear.
    assign accept_s    = valid_q & evt_ready;
    assign clr_s       = accept_s ? (N_BTN'(1) << id_q) : {N_BTN{1'b0}};
    assign drop_bits_s = btn_pulse & pend_q & ~clr_s;
    assign pend_d      = (pend_q & ~clr_s) | btn_pulse;
    assign drop_d      = sat_add(drop_q, popcnt(drop_bits_s));
    assign winner_s    = rr_pick(pend_q, ptr_q);
    assign ptr_next_s  = (id_q == ID_W'(N_BTN - 1)) ? {ID_W{1'b0}} : (id_q + ID_W'(1));

    // Request flags, drop counter and the IDLE/OFFER/HOLD sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
            hcnt_q  <= '0;
            pend_q  <= '0;
            drop_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
            case (state_q)
                ST_IDLE: begin
                    if (|pend_q) begin
                        state_q <= ST_OFFER;
                        valid_q <= 1'b1;
                        id_q    <= winner_s;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_OFFER: begin
                    if (accept_s) begin
                        valid_q <= 1'b0;
                        ptr_q   <= ptr_next_s;
                        if (HOLDOFF > 0) begin
                            state_q <= ST_HOLD;
                            hcnt_q  <= HC_W'(HOLDOFF);
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_OFFER;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hcnt_q <= HC_W'(1)) begin
                        state_q <= ST_IDLE;
                        hcnt_q  <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_HOLD;
                        hcnt_q  <= hcnt_q - HC_W'(1);
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid = valid_q;
    assign evt_id    = id_q;
    assign pending   = pend_q;
    assign drop_cnt  = drop_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Randomised and directed bench for button_event_arbiter: two instances (wide and 2-bit
// drop counter) checked every cycle against an event-level model plus literal expectations.
module tb_button_event_arbiter;

    localparam int HOLDOFF = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic       rdy;

    logic       valid_a, valid_b;
    logic [1:0] id_a, id_b;
    logic [3:0] pend_a, pend_b;
    logic [7:0] drop_a;
    logic [1:0] drop_b;
    logic       busy_a, busy_b;

    int total = 0;
    int bad   = 0;
    int got_ids[$];

    button_event_arbiter #(.N_BTN(4), .HOLDOFF(HOLDOFF), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst_n), .btn_pulse(btn), .evt_valid(valid_a), .evt_ready(rdy),
        .evt_id(id_a), .pending(pend_a), .drop_cnt(drop_a), .busy(busy_a)
    );

    button_event_arbiter #(.N_BTN(4), .HOLDOFF(HOLDOFF), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst_n), .btn_pulse(btn), .evt_valid(valid_b), .evt_ready(rdy),
        .evt_id(id_b), .pending(pend_b), .drop_cnt(drop_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event-level reference: an offer flag, a gap countdown before the next arbitration,
    // a rotating start index and an unbounded count of lost presses.
    logic       m_valid;
    logic [1:0] m_id;
    int         m_ptr;
    int         m_wait;
    logic [3:0] m_pend;
    int         m_drop;
    logic [3:0] m_clr;

    assign m_clr = (m_valid && rdy) ? (4'b0001 << m_id) : 4'b0000;

    function automatic int f_winner(input logic [3:0] p, input int ptr);
        for (int d = 0; d < 4; d++) begin
            int j;
            j = (ptr + d) % 4;
            if (((p >> j) & 4'b0001) != 4'b0000) return j;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_id    <= 2'd0;
            m_ptr   <= 0;
            m_wait  <= 0;
            m_pend  <= 4'b0000;
            m_drop  <= 0;
        end else begin
            m_pend <= (m_pend & ~m_clr) | btn;
            m_drop <= m_drop + $countones(btn & m_pend & ~m_clr);
            if (!m_valid && m_wait == 0) begin
                if (m_pend != 4'b0000) begin
                    m_valid <= 1'b1;
                    m_id    <= 2'(f_winner(m_pend, m_ptr));
                end
            end else if (m_valid && rdy) begin
                m_valid <= 1'b0;
                m_ptr   <= (int'(m_id) + 1) % 4;
                m_wait  <= HOLDOFF;
            end else if (m_wait > 0) begin
                m_wait <= m_wait - 1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int exp_busy;
        exp_busy = (m_valid || m_wait > 0) ? 1 : 0;
        check("m_valid_a", 32'(valid_a), 32'(m_valid));
        check("m_valid_b", 32'(valid_b), 32'(m_valid));
        check("m_id_a",    32'(id_a),    32'(m_id));
        check("m_id_b",    32'(id_b),    32'(m_id));
        check("m_pend_a",  32'(pend_a),  32'(m_pend));
        check("m_pend_b",  32'(pend_b),  32'(m_pend));
        check("m_busy_a",  32'(busy_a),  32'(exp_busy));
        check("m_busy_b",  32'(busy_b),  32'(exp_busy));
        check("m_drop_a",  32'(drop_a),  32'((m_drop > 255) ? 255 : m_drop));
        check("m_drop_b",  32'(drop_b),  32'((m_drop > 3) ? 3 : m_drop));
    endtask

    // Called at posedge+1: apply inputs for the coming edge, compare on the falling edge.
    task automatic cycle(input logic [3:0] p, input logic r);
        btn = p;
        rdy = r;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn   = 4'b0000;
        rdy   = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int n, input int budget);
        got_ids.delete();
        for (int c = 0; c < budget && got_ids.size() < n; c++) begin
            if (valid_a) got_ids.push_back(int'(id_a));
            cycle(4'b0000, 1'b1);
        end
        check("collect_count", 32'(got_ids.size()), 32'(n));
    endtask

    initial begin
        int hold_cycles;
        logic [3:0] p;
        logic r;

        rst_n = 1'b1;
        btn   = 4'hF;
        rdy   = 1'b0;
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_id",    32'(id_a),    32'd0);
        check("rst_pend",  32'(pend_a),  32'd0);
        check("rst_drop",  32'(drop_a),  32'd0);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_pend_b", 32'(pend_b), 32'd0);
        @(negedge clk);
        btn   = 4'b0000;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0000, 1'b1);
            check("idle_valid", 32'(valid_a), 32'd0);
        end

        // Single press of button 2: two-cycle latency, accept, then a 3-cycle hold-off.
        cycle(4'b0100, 1'b1);
        check("sp_pend", 32'(pend_a), 32'h4);
        check("sp_valid0", 32'(valid_a), 32'd0);
        cycle(4'b0000, 1'b1);
        check("sp_valid1", 32'(valid_a), 32'd1);
        check("sp_id", 32'(id_a), 32'd2);
        cycle(4'b0000, 1'b1);
        check("sp_acc_valid", 32'(valid_a), 32'd0);
        check("sp_acc_pend", 32'(pend_a), 32'd0);
        hold_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy_a) hold_cycles++;
            check("sp_gap_valid", 32'(valid_a), 32'd0);
            cycle(4'b0000, 1'b1);
        end
        check("sp_hold_len", 32'(hold_cycles), 32'd3);

        // Round-robin order from a fresh pointer.
        do_reset();
        cycle(4'hF, 1'b1);
        collect(4, 60);
        for (int i = 0; i < 4; i++) check("rr_order", 32'(got_ids.size() > i ? got_ids[i] : -1), 32'(i));
        cycle(4'b1001, 1'b1);
        collect(2, 30);
        check("rr_b0", 32'(got_ids.size() > 0 ? got_ids[0] : -1), 32'd0);
        check("rr_b1", 32'(got_ids.size() > 1 ? got_ids[1] : -1), 32'd3);
        check("rr_drop", 32'(drop_a), 32'd0);

        // Backpressure: offer must hold steady, re-presses are counted as drops.
        do_reset();
        cycle(4'b0010, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle((i == 5 || i == 10 || i == 15) ? 4'b0010 : 4'b0000, 1'b0);
            check("bp_valid", 32'(valid_a), 32'd1);
            check("bp_id", 32'(id_a), 32'd1);
        end
        check("bp_drop_a", 32'(drop_a), 32'd3);
        check("bp_drop_b", 32'(drop_b), 32'd3);
        cycle(4'b0000, 1'b1);
        check("bp_acc_valid", 32'(valid_a), 32'd0);
        check("bp_acc_pend", 32'(pend_a), 32'd0);

        // Re-press on the accept edge keeps the request alive.
        repeat (4) cycle(4'b0000, 1'b0);
        cycle(4'b0010, 1'b1);
        cycle(4'b0000, 1'b1);
        check("rp_valid", 32'(valid_a), 32'd1);
        check("rp_id", 32'(id_a), 32'd1);
        cycle(4'b0010, 1'b1);
        check("rp_pend", 32'(pend_a), 32'h2);
        check("rp_drop", 32'(drop_a), 32'd3);
        collect(1, 20);
        check("rp_id2", 32'(got_ids.size() > 0 ? got_ids[0] : -1), 32'd1);

        // Saturation of the 2-bit counter, then an asynchronous reset mid-offer.
        repeat (4) cycle(4'b0000, 1'b0);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) cycle(4'b0001, 1'b0);
        check("sat_drop_a", 32'(drop_a), 32'd8);
        check("sat_drop_b", 32'(drop_b), 32'd3);
        check("sat_valid", 32'(valid_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_valid_a", 32'(valid_a), 32'd0);
        check("ar_valid_b", 32'(valid_b), 32'd0);
        check("ar_drop_a", 32'(drop_a), 32'd0);
        check("ar_drop_b", 32'(drop_b), 32'd0);
        check("ar_pend", 32'(pend_a), 32'd0);
        check("ar_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(4'b1001, 1'b1);
        collect(1, 10);
        check("ar_ptr", 32'(got_ids.size() > 0 ? got_ids[0] : -1), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            p = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            cycle(p, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
